// File: rtl/bram_chk_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bram_chk_pkg
// Description : Shared types and helpers for the single-port BRAM read-data
//               checker: FSM state encoding, lane-width / latency helpers and
//               a saturating counter increment.
// Revision    : 1.0 - initial release
// ============================================================================
package bram_chk_pkg;

    // Checker lifecycle states, explicitly encoded
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } chk_state_t;

    // Width of one byte-enable lane
    function automatic int lane_width(input int data_width, input int byteen_width);
        return data_width / byteen_width;
    endfunction

    // Read latency of the BRAM: one extra stage when the output register is present
    function automatic int read_latency(input int output_reg);
        return (output_reg != 0) ? 2 : 1;
    endfunction

    // Increment that sticks at max_val instead of wrapping
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
        return (val >= max_val) ? val : val + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bram_chk_shadow.sv
`default_nettype none
// ============================================================================
// Module      : bram_chk_shadow
// Description : Byte-enabled shadow copy of the BRAM under test. Single shared
//               address, combinational read-first port (read returns the
//               contents before this cycle's write). Cleared to zero on rst.
// Revision    : 1.0 - initial release
// ============================================================================
module bram_chk_shadow
    import bram_chk_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 4,
    parameter int BYTEEN_WIDTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [BYTEEN_WIDTH-1:0] byteen,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH-1:0]   rdata
);

    localparam int c_LANE  = lane_width(DATA_WIDTH, BYTEEN_WIDTH);
    localparam int c_DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];

    // Lane-masked write; whole array cleared on reset to mirror the BRAM's zero INIT
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < c_DEPTH; j++) begin
                r_mem[j] <= '0;
            end
        end else if (we) begin
            for (int l = 0; l < BYTEEN_WIDTH; l++) begin
                if (byteen[l]) begin
                    r_mem[addr][l*c_LANE +: c_LANE] <= wdata[l*c_LANE +: c_LANE];
                end
            end
        end
    end

    // Read sees the pre-write contents because the write above lands at the edge
    assign rdata = r_mem[addr];

endmodule
`default_nettype wire

// File: rtl/bram_checker_sp.sv
`default_nettype none
// ============================================================================
// Module      : bram_checker_sp
// Description : Read-data monitor for the single-port BRAM bench. Snoops the
//               generator's controls, keeps a shadow model, compares every
//               read return and reports counts plus a pass/fail verdict once
//               sim_end is raised and in-flight reads have drained.
//               Optional console reporting: define BRAM_CHK_DISPLAY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module bram_checker_sp
    import bram_chk_pkg::*;
#(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDR_WIDTH    = 4,
    parameter int BYTEEN_WIDTH  = 2,
    parameter int OUTPUT_REG    = 1,
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     bram_rst,
    input  logic                     wclke,
    input  logic                     we,
    input  logic                     re,
    input  logic                     addren,
    input  logic [BYTEEN_WIDTH-1:0]  byteen,
    input  logic [ADDR_WIDTH-1:0]    addr,
    input  logic [DATA_WIDTH-1:0]    wdata_a,
    input  logic [DATA_WIDTH-1:0]    rdata_a,
    input  logic                     sim_end,
    output logic                     chk_valid,
    output logic                     chk_err,
    output logic [DATA_WIDTH-1:0]    exp_data,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt,
    output logic [ERR_CNT_WIDTH-1:0] rd_cnt,
    output logic                     done,
    output logic                     pass
);

    localparam int          c_LAT        = read_latency(OUTPUT_REG);
    localparam logic [1:0]  c_DRAIN_LAST = 2'(c_LAT);
    localparam logic [31:0] c_CNT_MAX    = 32'((64'd1 << ERR_CNT_WIDTH) - 64'd1);

    chk_state_t             r_state;
    chk_state_t             w_state_nxt;
    logic [1:0]             r_drain_cnt;
    logic                   w_accept;
    logic                   w_drain_last;
    logic                   w_done;
    logic                   w_pass;

    logic [ADDR_WIDTH-1:0]  r_addr_lat;
    logic [ADDR_WIDTH-1:0]  w_eff_addr;
    logic [DATA_WIDTH-1:0]  w_shadow_rd;

    logic                   r_pipe_vld [c_LAT];
    logic [DATA_WIDTH-1:0]  r_pipe_dat [c_LAT];
    logic                   w_mismatch;

    logic                     r_chk_valid;
    logic                     r_chk_err;
    logic [DATA_WIDTH-1:0]    r_exp_data;
    logic [ERR_CNT_WIDTH-1:0] r_err_cnt;
    logic [ERR_CNT_WIDTH-1:0] r_rd_cnt;

    // Address register as the BRAM sees it: only updates while addren is high
    assign w_eff_addr = addren ? addr : r_addr_lat;

    // Address latch follows addr whenever addren is asserted
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr_lat <= '0;
        end else if (addren) begin
            r_addr_lat <= addr;
        end
    end

    bram_chk_shadow #(
        .DATA_WIDTH   (DATA_WIDTH),
        .ADDR_WIDTH   (ADDR_WIDTH),
        .BYTEEN_WIDTH (BYTEEN_WIDTH)
    ) u_shadow (
        .clk    (clk),
        .rst    (rst),
        .we     (wclke & we),
        .byteen (byteen),
        .addr   (w_eff_addr),
        .wdata  (wdata_a),
        .rdata  (w_shadow_rd)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  w_state_nxt = ST_RUN;
            ST_RUN:   if (sim_end) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_drain_last) w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_DONE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs: read acceptance window, drain completion and verdict
    always_comb begin
        w_accept     = (r_state == ST_IDLE) || (r_state == ST_RUN);
        w_drain_last = (r_drain_cnt == c_DRAIN_LAST);
        w_done       = (r_state == ST_DONE);
        w_pass       = w_done && (r_err_cnt == '0) && (r_rd_cnt != '0);
    end

    // Drain timer: one extra cycle beyond the latency so the last compare is counted
    always_ff @(posedge clk) begin
        if (rst) begin
            r_drain_cnt <= '0;
        end else if (r_state == ST_DRAIN) begin
            r_drain_cnt <= r_drain_cnt + 2'd1;
        end else begin
            r_drain_cnt <= '0;
        end
    end

    // Expected-data pipeline, aligned to the BRAM read latency
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_LAT; i++) begin
                r_pipe_vld[i] <= 1'b0;
                r_pipe_dat[i] <= '0;
            end
        end else begin
            r_pipe_vld[0] <= re & w_accept;
            r_pipe_dat[0] <= w_shadow_rd;
            for (int i = 1; i < c_LAT; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                r_pipe_dat[i] <= r_pipe_dat[i-1];
            end
            // A reset output register presents zero for the entry it would have held
            if ((OUTPUT_REG != 0) && bram_rst) begin
                r_pipe_dat[c_LAT-1] <= '0;
            end
        end
    end

    assign w_mismatch = (r_pipe_dat[c_LAT-1] != rdata_a);

    // Compare stage: registered verdict per read plus saturating tallies
    always_ff @(posedge clk) begin
        if (rst) begin
            r_chk_valid <= 1'b0;
            r_chk_err   <= 1'b0;
            r_exp_data  <= '0;
            r_err_cnt   <= '0;
            r_rd_cnt    <= '0;
        end else begin
            r_chk_valid <= r_pipe_vld[c_LAT-1];
            r_chk_err   <= r_pipe_vld[c_LAT-1] & w_mismatch;
            if (r_pipe_vld[c_LAT-1]) begin
                r_exp_data <= r_pipe_dat[c_LAT-1];
                r_rd_cnt   <= ERR_CNT_WIDTH'(sat_inc(32'(r_rd_cnt), c_CNT_MAX));
                if (w_mismatch) begin
                    r_err_cnt <= ERR_CNT_WIDTH'(sat_inc(32'(r_err_cnt), c_CNT_MAX));
                end
            end
        end
    end

    assign chk_valid = r_chk_valid;
    assign chk_err   = r_chk_err;
    assign exp_data  = r_exp_data;
    assign err_cnt   = r_err_cnt;
    assign rd_cnt    = r_rd_cnt;
    assign done      = w_done;
    assign pass      = w_pass;

`ifdef BRAM_CHK_DISPLAY_EN
    logic [ADDR_WIDTH-1:0] r_pipe_adr [c_LAT];

    // Address tag travelling alongside each read for mismatch reports
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_LAT; i++) begin
                r_pipe_adr[i] <= '0;
            end
        end else begin
            r_pipe_adr[0] <= w_eff_addr;
            for (int i = 1; i < c_LAT; i++) begin
                r_pipe_adr[i] <= r_pipe_adr[i-1];
            end
        end
    end

    // Console report of each mismatch and of the final verdict
    always_ff @(posedge clk) begin
        if (!rst && r_pipe_vld[c_LAT-1] && w_mismatch) begin
            $display("[%0t] bram_checker_sp: addr %0h expected %h actual %h",
                     $time, r_pipe_adr[c_LAT-1], r_pipe_dat[c_LAT-1], rdata_a);
        end
        if (!rst && (r_state != ST_DONE) && (w_state_nxt == ST_DONE)) begin
            $display("[%0t] bram_checker_sp: reads %0d errors %0d", $time, r_rd_cnt, r_err_cnt);
            if ((r_err_cnt == '0) && (r_rd_cnt != '0)) begin
                $display("[%0t] bram_checker_sp: PASS", $time);
            end else begin
                $display("[%0t] bram_checker_sp: FAIL", $time);
            end
        end
    end
`else
    // Silent build: ports behave identically, nothing is printed
`endif

endmodule
`default_nettype wire

// File: tb/tb_bram_checker_sp.sv
`default_nettype none
// ============================================================================
// Module      : tb_bram_checker_sp
// Description : Directed bench for bram_checker_sp with a small BRAM model
//               (latency 2) driving rdata_a and a scoreboard of expected
//               compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bram_checker_sp;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int BW = 2;
    localparam int CW = 16;

    logic          clk;
    logic          rst;
    logic          bram_rst;
    logic          wclke;
    logic          we;
    logic          re;
    logic          addren;
    logic [BW-1:0] byteen;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata_a;
    logic [DW-1:0] rdata_a;
    logic          sim_end;
    logic          chk_valid;
    logic          chk_err;
    logic [DW-1:0] exp_data;
    logic [CW-1:0] err_cnt;
    logic [CW-1:0] rd_cnt;
    logic          done;
    logic          pass;

    typedef struct {
        logic [DW-1:0] d;
        logic          e;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_vec  = 0;
    int   n_fail = 0;
    int   exp_rd = 0;
    int   rd_snap;

    // BRAM model with address register and output register
    logic [DW-1:0] m_mem [16];
    logic [AW-1:0] m_alat;
    logic [AW-1:0] m_ea;
    logic [DW-1:0] m_q1;
    logic [DW-1:0] m_q2;
    logic          force_ff;

    bram_checker_sp #(
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .BYTEEN_WIDTH  (BW),
        .OUTPUT_REG    (1),
        .ERR_CNT_WIDTH (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bram_rst  (bram_rst),
        .wclke     (wclke),
        .we        (we),
        .re        (re),
        .addren    (addren),
        .byteen    (byteen),
        .addr      (addr),
        .wdata_a   (wdata_a),
        .rdata_a   (rdata_a),
        .sim_end   (sim_end),
        .chk_valid (chk_valid),
        .chk_err   (chk_err),
        .exp_data  (exp_data),
        .err_cnt   (err_cnt),
        .rd_cnt    (rd_cnt),
        .done      (done),
        .pass      (pass)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign m_ea    = addren ? addr : m_alat;
    assign rdata_a = force_ff ? 16'hFFFF : m_q2;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) m_mem[i] <= '0;
            m_alat <= '0;
            m_q1   <= '0;
            m_q2   <= '0;
        end else begin
            if (addren) m_alat <= addr;
            if (wclke && we) begin
                if (byteen[0]) m_mem[m_ea][7:0]  <= wdata_a[7:0];
                if (byteen[1]) m_mem[m_ea][15:8] <= wdata_a[15:8];
            end
            if (re) m_q1 <= m_mem[m_ea];
            m_q2 <= bram_rst ? 16'h0000 : m_q1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input logic [DW-1:0] d, input logic e);
        exp_t t;
        t.d = d;
        t.e = e;
        sb.push_back(t);
        exp_rd++;
    endtask

    task automatic idle_in();
        wclke = 1'b0; we = 1'b0; re = 1'b0; addren = 1'b1; byteen = 2'b11;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [BW-1:0] be, input logic aen);
        wclke = 1'b1; we = 1'b1; re = 1'b0; addren = aen;
        addr = a; wdata_a = d; byteen = be;
        @(negedge clk);
        idle_in();
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] e, input logic aen);
        wclke = 1'b0; we = 1'b0; re = 1'b1; addren = aen; addr = a;
        push_exp(e, 1'b0);
        @(negedge clk);
        idle_in();
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_chk_valid"}, 32'(chk_valid), 0);
        chk({tag, "_chk_err"},   32'(chk_err),   0);
        chk({tag, "_exp_data"},  32'(exp_data),  0);
        chk({tag, "_err_cnt"},   32'(err_cnt),   0);
        chk({tag, "_rd_cnt"},    32'(rd_cnt),    0);
        chk({tag, "_done"},      32'(done),      0);
        chk({tag, "_pass"},      32'(pass),      0);
    endtask

    // Scoreboard consumer: every compare pulse must match the next expectation
    always @(negedge clk) begin
        if (!rst && chk_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_fail++;
                $error("FAIL unexpected_compare: observed chk_valid 1 expected 0");
            end else begin
                mon_e = sb.pop_front();
                chk("exp_data", 32'(exp_data), 32'(mon_e.d));
                chk("chk_err",  32'(chk_err),  32'(mon_e.e));
            end
        end
    end

    initial begin
        rst = 1'b1; bram_rst = 1'b0; sim_end = 1'b0; force_ff = 1'b0;
        addr = '0; wdata_a = '0;
        idle_in();
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_done", 32'(done), 0);

        // Zero-initialised sweep of every address, back to back
        for (int a = 0; a < 16; a++) rd(AW'(a), 16'h0000, 1'b1);
        settle();
        chk("sweep_rd_cnt",  32'(rd_cnt),  16);
        chk("sweep_err_cnt", 32'(err_cnt), 0);

        // Low-lane-only write
        wr(4'd3, 16'hA5A5, 2'b01, 1'b1);
        rd(4'd3, 16'h00A5, 1'b1);

        // Same-cycle write and read: read returns the old contents
        wr(4'd7, 16'h5555, 2'b11, 1'b1);
        wclke = 1'b1; we = 1'b1; re = 1'b1; addren = 1'b1; addr = 4'd7;
        wdata_a = 16'h1234; byteen = 2'b11;
        push_exp(16'h5555, 1'b0);
        @(negedge clk);
        idle_in();
        rd(4'd7, 16'h1234, 1'b1);

        // addren low: write goes to the latched address
        wr(4'd9, 16'h0999, 2'b11, 1'b1);
        wr(4'd2, 16'h2222, 2'b11, 1'b1);
        wr(4'd9, 16'hBEEF, 2'b11, 1'b0);
        rd(4'd9, 16'h0999, 1'b1);
        rd(4'd2, 16'hBEEF, 1'b1);
        rd(4'd5, 16'hBEEF, 1'b0);
        settle();

        // Output-register reset zeroes the read in the output stage only
        re = 1'b1; addr = 4'd3;
        push_exp(16'h0000, 1'b0);
        @(negedge clk);
        re = 1'b1; addr = 4'd7; bram_rst = 1'b1;
        push_exp(16'h1234, 1'b0);
        @(negedge clk);
        re = 1'b0; bram_rst = 1'b0;
        settle();
        chk("mid_rd_cnt",  32'(rd_cnt),  32'(exp_rd));
        chk("mid_err_cnt", 32'(err_cnt), 0);
        chk("mid_pass",    32'(pass),    0);

        // End of stimulus with two reads in flight; read during drain is ignored
        rd(4'd0, 16'h0000, 1'b1);
        sim_end = 1'b1;
        rd(4'd2, 16'hBEEF, 1'b1);
        re = 1'b1; addr = 4'd3;
        @(negedge clk);
        re = 1'b0;
        chk("drain1_done", 32'(done), 0);
        @(negedge clk);
        chk("drain2_done", 32'(done), 0);
        @(negedge clk);
        chk("end_done",    32'(done),    1);
        chk("end_pass",    32'(pass),    1);
        chk("end_rd_cnt",  32'(rd_cnt),  32'(exp_rd));
        chk("end_err_cnt", 32'(err_cnt), 0);

        // Reads after DONE are ignored
        rd_snap = exp_rd;
        re = 1'b1; addr = 4'd1;
        @(negedge clk);
        re = 1'b0;
        settle();
        chk("after_done_rd_cnt", 32'(rd_cnt), 32'(rd_snap));
        chk("after_done_sticky", 32'(done),   1);
        sim_end = 1'b0;

        // Reset with a read in flight discards it and clears everything
        re = 1'b1; addr = 4'd7;
        @(negedge clk);
        re = 1'b0; rst = 1'b1;
        exp_rd = 0;
        repeat (2) @(negedge clk);
        chk_reset_vals("midrst");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_rst_valid", 32'(chk_valid), 0);

        // Shadow cleared by reset, then an injected bad read
        rd(4'd3, 16'h0000, 1'b1);
        wr(4'd3, 16'hA5A5, 2'b01, 1'b1);
        re = 1'b1; addr = 4'd3;
        push_exp(16'h00A5, 1'b1);
        @(negedge clk);
        re = 1'b0;
        @(negedge clk);
        force_ff = 1'b1;
        @(negedge clk);
        force_ff = 1'b0;
        settle();
        chk("err_err_cnt", 32'(err_cnt), 1);
        chk("err_rd_cnt",  32'(rd_cnt),  32'(exp_rd));

        sim_end = 1'b1;
        repeat (4) @(negedge clk);
        chk("err_done",     32'(done),    1);
        chk("err_pass",     32'(pass),    0);
        chk("err_final_ec", 32'(err_cnt), 1);

        chk("sb_drained", 32'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
